// File: rtl/uut_run_ctrl.sv
// UUT run controller: programmable-ratio clock enable, UUT reset sequencing,
// run supervision with end/timeout detection and UUT period counting.
module uut_run_ctrl #(
  parameter int DIV_WIDTH  = 8,
  parameter int CNT_WIDTH  = 32,
  parameter int RST_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DIV_WIDTH-1:0] div_sel,
  input  logic [CNT_WIDTH-1:0] timeout_cycles,
  input  logic                 end_uut,
  output logic                 uut_clk_en,
  output logic                 rst_uut,
  output logic                 busy,
  output logic                 done,
  output logic                 timed_out,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RESET_UUT,
    RUN,
    DONE
  } state_t;

  state_t               state, state_next;
  logic                 start_q;
  logic [DIV_WIDTH-1:0] div_reg, div_reg_next;
  logic [DIV_WIDTH-1:0] div_cnt, div_cnt_next, div_wrap;
  logic [CNT_WIDTH-1:0] tmo_reg, tmo_reg_next;
  logic [CNT_WIDTH-1:0] cnt_next, cnt_inc;
  logic [RW-1:0]        rst_cnt, rst_cnt_next;
  logic                 timed_out_next, rst_uut_next, busy_next, done_next;
  logic                 run_phase;

  // Enable is decoded purely from registers so it cannot glitch.
  assign run_phase  = (state == RESET_UUT) || (state == RUN);
  assign uut_clk_en = run_phase && (div_cnt == div_reg);
  assign div_wrap   = uut_clk_en ? '0 : div_cnt + 1'b1;
  assign cnt_inc    = (&cycle_count) ? cycle_count : cycle_count + 1'b1;

  always_comb begin
    state_next     = state;
    div_reg_next   = div_reg;
    tmo_reg_next   = tmo_reg;
    div_cnt_next   = '0;
    rst_cnt_next   = rst_cnt;
    cnt_next       = cycle_count;
    timed_out_next = timed_out;
    rst_uut_next   = rst_uut;

    case (state)
      IDLE: begin
        if (start && !start_q) begin
          state_next     = RESET_UUT;
          div_reg_next   = div_sel;
          tmo_reg_next   = timeout_cycles;
          rst_cnt_next   = '0;
          cnt_next       = '0;
          timed_out_next = 1'b0;
          rst_uut_next   = 1'b1;
        end
      end
      RESET_UUT: begin
        div_cnt_next = div_wrap;
        if (uut_clk_en) begin
          if (rst_cnt == RST_LAST) begin
            state_next   = RUN;
            rst_uut_next = 1'b0;
            div_cnt_next = '0;
          end else begin
            rst_cnt_next = rst_cnt + 1'b1;
          end
        end
      end
      RUN: begin
        div_cnt_next = div_wrap;
        if (uut_clk_en) cnt_next = cnt_inc;
        // end_uut takes priority over a coincident timeout.
        if (end_uut) begin
          state_next     = DONE;
          timed_out_next = 1'b0;
          div_cnt_next   = '0;
        end else if (uut_clk_en && (tmo_reg != '0) && (cnt_inc == tmo_reg)) begin
          state_next     = DONE;
          timed_out_next = 1'b1;
          div_cnt_next   = '0;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next == RESET_UUT) || (state_next == RUN);
    done_next = (state_next == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      start_q     <= 1'b0;
      div_reg     <= '0;
      tmo_reg     <= '0;
      div_cnt     <= '0;
      rst_cnt     <= '0;
      cycle_count <= '0;
      timed_out   <= 1'b0;
      rst_uut     <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_next;
      start_q     <= start;
      div_reg     <= div_reg_next;
      tmo_reg     <= tmo_reg_next;
      div_cnt     <= div_cnt_next;
      rst_cnt     <= rst_cnt_next;
      cycle_count <= cnt_next;
      timed_out   <= timed_out_next;
      rst_uut     <= rst_uut_next;
      busy        <= busy_next;
      done        <= done_next;
    end
  end

endmodule

// File: doc/uut_run_ctrl.md
# uut_run_ctrl

Parametrised successor to the fixed UUT clock generator in the autotest flow. It produces a programmable-ratio clock enable for the unit under test (UUT) from the single system clock, and sequences the UUT reset. It runs the UUT until `end_uut` or a programmable timeout, and reports the number of UUT clock periods consumed. The block sits between the autotest control FSM and the UUT, and replaces the clock mux and divider with a single-domain enable scheme.

## Interface
Parameters:
- DIV_WIDTH, 8: width of the divide-select input; divide ratio is div_sel+1 (1..2^DIV_WIDTH).
- CNT_WIDTH, 32: width of the cycle counter and the timeout value.
- RST_CYCLES, 4: number of UUT enable pulses for which rst_uut is held high before the run starts; must be ≥1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  run request; the rising edge is detected internally.
- div_sel  in  DIV_WIDTH  divide select, latched at start.
- timeout_cycles  in  CNT_WIDTH  maximum number of UUT enable pulses in RUN, latched at start; 0 disables the timeout.
- end_uut  in  1  UUT completion flag, sampled every clk in RUN.
- uut_clk_en  out  1  UUT clock enable, one clk wide per UUT period.
- rst_uut  out  1  active-high UUT reset.
- busy  out  1  high in RESET_UUT and RUN.
- done  out  1  one-cycle pulse when a run finishes.
- timed_out  out  1  the last run ended by timeout; held until the next start.
- cycle_count  out  CNT_WIDTH  enable pulses delivered in RUN; held until the next start.

## Operation
- States: IDLE, RESET_UUT, RUN, DONE. Reset value is IDLE.
- Start edge: start_q is a registered copy of start. A start edge is start=1 and start_q=0 in IDLE. Start edges in any state other than IDLE are ignored.
- IDLE → RESET_UUT on a start edge. On that edge:
  - latch div_reg←div_sel and tmo_reg←timeout_cycles;
  - clear div_cnt, rst_cnt, cycle_count and timed_out;
  - set rst_uut=1.
- Divider: div_cnt counts 0..div_reg and wraps to 0. It runs only in RESET_UUT and RUN; it is held at 0 otherwise.
- uut_clk_en = (state∈{RESET_UUT,RUN}) && div_cnt==div_reg. It is decoded from registers only, so it is glitch-free. With div_reg=0 it is high every cycle.
- RESET_UUT: rst_cnt increments on each enable pulse. On the pulse where rst_cnt==RST_CYCLES-1, the block goes to RUN, clears rst_uut and resets div_cnt to 0.
- RUN: cycle_count increments on each enable pulse and saturates at all-ones.
  - end_uut=1 → DONE with timed_out=0. A pulse in the same cycle is still counted.
  - Otherwise, tmo_reg≠0 and a pulse that brings cycle_count to tmo_reg → DONE with timed_out=1.
  - end_uut together with the timeout condition in the same cycle → end_uut wins, timed_out=0.
- DONE: lasts exactly one cycle with done=1, then → IDLE. rst_uut stays 0 and uut_clk_en stays 0, so UUT outputs are frozen for readback.
- Changes to div_sel or timeout_cycles during a run have no effect.
- rst_uut after power-on reset is 1; after a completed run it stays 0 until the next start.
- Asserting rst at any time, including mid-run, returns all outputs to their reset values immediately.

## Timing
- Reset values: uut_clk_en=0, rst_uut=1, busy=0, done=0, timed_out=0, cycle_count=0, state=IDLE.
- Start edge sampled at edge k → busy=1 and state=RESET_UUT after edge k. The first enable pulse comes in cycle k+1+div_reg.
- With div_reg=0, RESET_UUT lasts RST_CYCLES clk cycles. rst_uut falls after edge k+RST_CYCLES, and RUN starts in the same cycle.
- In general, RESET_UUT lasts RST_CYCLES×(div_reg+1) cycles, and UUT periods in RUN are div_reg+1 clk cycles.
- end_uut sampled high at edge m → done=1 and busy=0 during cycle m+1; IDLE from m+2. A new start edge is accepted from cycle m+2.
- All outputs except uut_clk_en are registered.

## Test plan
- Reset: hold rst=0 for 3 cycles → rst_uut=1, uut_clk_en=0, busy=0, cycle_count=0. Release and idle 10 cycles → no uut_clk_en pulse.
- Basic run: div_sel=0, timeout=0, start edge at cycle 0.
  - Expected: rst_uut high for 4 pulses, then RUN.
  - end_uut raised in the 10th RUN cycle → cycle_count=10, timed_out=0, one done pulse.
- Divided run: div_sel=3, RST_CYCLES=4.
  - Expected: uut_clk_en high 1 of every 4 cycles; rst_uut falls 16 cycles after the start edge.
  - end_uut after 5 RUN pulses → cycle_count=5.
- Timeout and priority:
  - div_sel=1, timeout=7, end_uut never raised → done after the 7th pulse, cycle_count=7, timed_out=1.
  - Repeat with end_uut raised in the 7th-pulse cycle → timed_out=0.
- Ignored inputs: start toggled and div_sel changed to 5 mid-RUN → no restart, enable period unchanged. Start held high after done → no second run until start goes low then high again.
- Mid-run reset: rst=0 in RUN with cycle_count=20 → all outputs at reset values immediately. After release, a new start runs normally from a count of 0.
